// File: rtl/ase_pcie_ss_tx_arbiter.sv
// ase_pcie_ss_tx_arbiter
//   Packet-atomic round-robin merge of NUM_PORTS AFU->host TLP AXI-S streams
//   into the single TX stream of the PCIe SS emulator. A port that wins
//   arbitration keeps the output until its tlast beat, so beats of different
//   packets never interleave. The output stage is a flop, and the beat that
//   wins a cycle is loaded into it in that same cycle (no idle bubble).
// Ports
//   clk_i, rst_ni            clock, synchronous active-low reset
//   in_tvalid_i/in_tlast_i   per-port beat valid / end of packet
//   in_tdata_i/tkeep_i/tuser_i  flat per-port buses, port i at slice i
//   in_tready_o              per-port ready (0 for every port during reset)
//   out_t*_o                 registered merged stream
//   out_src_o                port that sourced the current output beat
//   out_tready_i             emulator ready
//   pkt_count_o              per-port count of accepted tlast beats (wraps)
module ase_pcie_ss_tx_arbiter #(
  parameter int NUM_PORTS   = 2,
  parameter int TDATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 10,
  parameter int CNT_WIDTH   = 32,
  localparam int TKEEP_WIDTH = TDATA_WIDTH / 8,
  localparam int SRC_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_PORTS-1:0]             in_tvalid_i,
  input  logic [NUM_PORTS-1:0]             in_tlast_i,
  input  logic [NUM_PORTS*TDATA_WIDTH-1:0] in_tdata_i,
  input  logic [NUM_PORTS*TKEEP_WIDTH-1:0] in_tkeep_i,
  input  logic [NUM_PORTS*TUSER_WIDTH-1:0] in_tuser_i,
  output logic [NUM_PORTS-1:0]             in_tready_o,
  output logic                             out_tvalid_o,
  output logic                             out_tlast_o,
  output logic [TDATA_WIDTH-1:0]           out_tdata_o,
  output logic [TKEEP_WIDTH-1:0]           out_tkeep_o,
  output logic [TUSER_WIDTH-1:0]           out_tuser_o,
  output logic [SRC_W-1:0]                 out_src_o,
  input  logic                             out_tready_i,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]   pkt_count_o
);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  logic                                 state_q, state_d;
  logic [SRC_W-1:0]                     owner_q, owner_d;
  logic [SRC_W-1:0]                     rr_ptr_q, rr_ptr_d;
  logic                                 tvalid_q, tvalid_d;
  logic                                 tlast_q, tlast_d;
  logic [TDATA_WIDTH-1:0]               tdata_q, tdata_d;
  logic [TKEEP_WIDTH-1:0]               tkeep_q, tkeep_d;
  logic [TUSER_WIDTH-1:0]               tuser_q, tuser_d;
  logic [SRC_W-1:0]                     src_q, src_d;
  logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [SRC_W-1:0] grant, sel;
  logic             any_vld, sel_vld, can_load, xfer;
  int               idx;

  // Round-robin search starting at rr_ptr. Walking the offsets downwards lets
  // the smallest valid offset be the last (winning) assignment.
  always_comb begin
    grant   = '0;
    any_vld = 1'b0;
    idx     = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % NUM_PORTS;
      if (in_tvalid_i[idx]) begin
        grant   = SRC_W'(idx);
        any_vld = 1'b1;
      end
    end
  end

  assign can_load = !tvalid_q || out_tready_i;
  assign sel      = (state_q == ST_LOCKED) ? owner_q : grant;
  assign sel_vld  = (state_q == ST_LOCKED) ? in_tvalid_i[sel] : any_vld;
  assign xfer     = rst_ni && can_load && sel_vld;

  // Once locked the owner keeps ready even while it bubbles, so nobody else
  // can slip a beat into the middle of its packet.
  always_comb begin
    in_tready_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      in_tready_o[p] = rst_ni && can_load && (sel == SRC_W'(p)) &&
                       ((state_q == ST_LOCKED) || any_vld);
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tuser_d  = tuser_q;
    src_d    = src_q;
    cnt_d    = cnt_q;
    if (can_load) tvalid_d = xfer;
    if (xfer) begin
      tlast_d = in_tlast_i[sel];
      tdata_d = in_tdata_i[int'(sel)*TDATA_WIDTH +: TDATA_WIDTH];
      tkeep_d = in_tkeep_i[int'(sel)*TKEEP_WIDTH +: TKEEP_WIDTH];
      tuser_d = in_tuser_i[int'(sel)*TUSER_WIDTH +: TUSER_WIDTH];
      src_d   = sel;
      if (in_tlast_i[sel]) begin
        // priority only moves at packet ends, so every packet weighs the same
        state_d    = ST_IDLE;
        rr_ptr_d   = (int'(sel) == NUM_PORTS - 1) ? '0 : sel + 1'b1;
        cnt_d[sel] = cnt_q[sel] + CNT_WIDTH'(1);
      end else begin
        state_d = ST_LOCKED;
        owner_d = sel;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tuser_q  <= '0;
      src_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tuser_q  <= tuser_d;
      src_q    <= src_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_tvalid_o = tvalid_q;
  assign out_tlast_o  = tlast_q;
  assign out_tdata_o  = tdata_q;
  assign out_tkeep_o  = tkeep_q;
  assign out_tuser_o  = tuser_q;
  assign out_src_o    = src_q;
  assign pkt_count_o  = cnt_q;

endmodule

// File: tb/tb_ase_pcie_ss_tx_arbiter.sv
// Bench for ase_pcie_ss_tx_arbiter: 2 ports, 64-bit data, 4-bit counters.
// A behavioural model checks every cycle; directed scenarios add literal checks.
module tb_ase_pcie_ss_tx_arbiter;

  localparam int NP = 2;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int UW = 10;
  localparam int CW = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  typedef struct packed {
    int            cyc;
    logic          src;
    logic          last;
    logic [DW-1:0] data;
  } obeat_t;

  logic             clk;
  logic             rst_n;
  logic [NP-1:0]    in_tvalid, in_tlast, in_tready;
  logic [NP*DW-1:0] in_tdata;
  logic [NP*KW-1:0] in_tkeep;
  logic [NP*UW-1:0] in_tuser;
  logic             out_tvalid, out_tlast, out_tready;
  logic [DW-1:0]    out_tdata;
  logic [KW-1:0]    out_tkeep;
  logic [UW-1:0]    out_tuser;
  logic [0:0]       out_src;
  logic [NP*CW-1:0] pkt_count;

  ase_pcie_ss_tx_arbiter #(
    .NUM_PORTS(NP), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_tvalid_i(in_tvalid), .in_tlast_i(in_tlast), .in_tdata_i(in_tdata),
    .in_tkeep_i(in_tkeep), .in_tuser_i(in_tuser), .in_tready_o(in_tready),
    .out_tvalid_o(out_tvalid), .out_tlast_o(out_tlast), .out_tdata_o(out_tdata),
    .out_tkeep_o(out_tkeep), .out_tuser_o(out_tuser), .out_src_o(out_src),
    .out_tready_i(out_tready), .pkt_count_o(pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int tag  = 0;

  beat_t  q0[$], q1[$];
  beat_t  pushed[$];
  obeat_t olog[$];
  logic   pause0 = 1'b0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // ---------------- model + per-cycle compare ----------------
  logic          m_init = 1'b0, m_ov, m_last, m_src, m_chk_all;
  int            m_owner, m_rr;
  int            m_cnt[NP];
  logic [DW-1:0] m_data;
  logic [KW-1:0] m_keep;
  logic [UW-1:0] m_user;

  always @(negedge clk) begin
    int sel;
    int p;
    logic can, xf;
    logic [NP-1:0] exp_rdy;
    cyc++;
    if (!rst_n) begin
      chk("rst_in_tready", 128'(in_tready), 128'(0));
      m_init = 1'b1; m_ov = 1'b0; m_owner = -1; m_rr = 0;
      m_cnt[0] = 0; m_cnt[1] = 0;
      m_data = '0; m_keep = '0; m_user = '0; m_last = 1'b0; m_src = 1'b0;
      m_chk_all = 1'b1;
    end else if (m_init) begin
      chk("out_tvalid", 128'(out_tvalid), 128'(m_ov));
      if (m_ov || m_chk_all) begin
        chk("out_tdata", 128'(out_tdata), 128'(m_data));
        chk("out_tkeep", 128'(out_tkeep), 128'(m_keep));
        chk("out_tuser", 128'(out_tuser), 128'(m_user));
        chk("out_tlast", 128'(out_tlast), 128'(m_last));
        chk("out_src",   128'(out_src),   128'(m_src));
      end
      chk("pkt_count", 128'(pkt_count), 128'({4'(m_cnt[1]), 4'(m_cnt[0])}));
      m_chk_all = 1'b0;
      can = !m_ov || out_tready;
      sel = -1;
      if (m_owner >= 0) sel = m_owner;
      else for (int k = 0; k < NP; k++) begin
        p = (m_rr + k) % NP;
        if (sel < 0 && in_tvalid[p]) sel = p;
      end
      exp_rdy = (sel >= 0 && can) ? NP'(1 << sel) : '0;
      chk("in_tready", 128'(in_tready), 128'(exp_rdy));
      if (out_tvalid && out_tready)
        olog.push_back('{cyc: cyc, src: out_src[0], last: out_tlast, data: out_tdata});
      xf = (sel >= 0) && can && in_tvalid[sel];
      if (can) m_ov = xf;
      if (xf) begin
        m_data = in_tdata[sel*DW +: DW];
        m_keep = in_tkeep[sel*KW +: KW];
        m_user = in_tuser[sel*UW +: UW];
        m_last = in_tlast[sel];
        m_src  = sel[0];
        if (in_tlast[sel]) begin
          m_owner = -1;
          m_rr = (sel + 1) % NP;
          m_cnt[sel] = (m_cnt[sel] + 1) % 16;
        end else m_owner = sel;
      end
    end
  end

  // ---------------- source drivers ----------------
  task automatic push_pkt(input int p, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      tag++;
      b.data = (64'(p) << 60) | 64'(tag);
      b.keep = 8'(tag * 37);
      b.user = 10'(tag * 3);
      b.last = (i == n - 1);
      if (p == 0) q0.push_back(b); else q1.push_back(b);
      pushed.push_back(b);
    end
  endtask

  task automatic drive();
    in_tvalid = '0;
    in_tlast  = '0;
    if (q0.size() > 0 && !pause0) begin
      in_tvalid[0] = 1'b1; in_tlast[0] = q0[0].last;
      in_tdata[0 +: DW] = q0[0].data; in_tkeep[0 +: KW] = q0[0].keep; in_tuser[0 +: UW] = q0[0].user;
    end
    if (q1.size() > 0) begin
      in_tvalid[1] = 1'b1; in_tlast[1] = q1[0].last;
      in_tdata[DW +: DW] = q1[0].data; in_tkeep[KW +: KW] = q1[0].keep; in_tuser[UW +: UW] = q1[0].user;
    end
  endtask

  // one clock: note handshakes before the edge, then advance the sources
  task automatic tick();
    logic [NP-1:0] hs;
    @(negedge clk);
    hs = in_tvalid & in_tready;
    @(posedge clk);
    #1;
    if (hs[0]) void'(q0.pop_front());
    if (hs[1]) void'(q1.pop_front());
    drive();
  endtask

  task automatic run_idle(input logic bp);
    logic [3:0] pat;
    logic done;
    pat  = 4'b1001;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      if (bp) out_tready = pat[i % 4];
      if (q0.size() == 0 && q1.size() == 0 && in_tvalid == '0 && !out_tvalid) done = 1'b1;
    end
    out_tready = 1'b1;
    chk("drain_timeout", 128'(done), 128'(1));
  endtask

  task automatic clear_logs();
    olog.delete();
    pushed.delete();
  endtask

  initial begin
    int bad;
    int c0;
    rst_n = 1'b0; out_tready = 1'b1;
    in_tvalid = '0; in_tlast = '0; in_tdata = '0; in_tkeep = '0; in_tuser = '0;

    // reset with traffic already pending on both ports
    push_pkt(0, 1); push_pkt(1, 1); drive();
    repeat (4) begin
      tick();
      chk("rst_hold_in_tready", 128'(in_tready), 128'(0));
      chk("rst_hold_out_tvalid", 128'(out_tvalid), 128'(0));
      chk("rst_hold_pkt_count", 128'(pkt_count), 128'(0));
    end
    rst_n = 1'b1;
    run_idle(1'b0);
    chk("rst_first_len", 128'(olog.size()), 128'(2));
    if (olog.size() == 2) begin
      chk("rst_first_src0", 128'(olog[0].src), 128'(0));
      chk("rst_first_src1", 128'(olog[1].src), 128'(1));
    end

    // single port, 3-beat packet
    clear_logs();
    c0 = cyc;
    push_pkt(1, 3); drive();
    run_idle(1'b0);
    chk("single_len", 128'(olog.size()), 128'(3));
    if (olog.size() == 3) begin
      chk("single_latency", 128'(olog[0].cyc), 128'(c0 + 2));
      chk("single_span", 128'(olog[2].cyc - olog[0].cyc), 128'(2));
      bad = 0;
      for (int i = 0; i < 3; i++) begin
        if (olog[i].src !== 1'b1) bad++;
        if (olog[i].last !== (i == 2)) bad++;
        if (olog[i].data !== pushed[i].data) bad++;
      end
      chk("single_beats", 128'(bad), 128'(0));
    end
    chk("single_count", 128'(pkt_count), 128'(8'h21));

    // contention: 10 two-beat packets per port
    clear_logs();
    for (int i = 0; i < 10; i++) begin push_pkt(0, 2); push_pkt(1, 2); end
    drive();
    run_idle(1'b0);
    chk("cont_len", 128'(olog.size()), 128'(40));
    if (olog.size() == 40) begin
      bad = 0;
      for (int i = 0; i < 40; i++) begin
        if (olog[i].src !== 1'((i / 2) % 2)) bad++;
        if (olog[i].last !== (i % 2 == 1)) bad++;
      end
      chk("cont_order", 128'(bad), 128'(0));
      chk("cont_throughput", 128'(olog[39].cyc - olog[0].cyc), 128'(39));
    end
    chk("cont_count", 128'(pkt_count), 128'(8'hCB));

    // backpressure during a 4-beat packet
    clear_logs();
    push_pkt(0, 4); drive();
    run_idle(1'b1);
    chk("bp_len", 128'(olog.size()), 128'(4));
    if (olog.size() == 4) begin
      bad = 0;
      for (int i = 0; i < 4; i++) begin
        if (olog[i].data !== pushed[i].data) bad++;
        if (olog[i].last !== (i == 3)) bad++;
        if (olog[i].src !== 1'b0) bad++;
      end
      chk("bp_beats", 128'(bad), 128'(0));
    end
    chk("bp_count", 128'(pkt_count), 128'(8'hCC));

    // owner bubble: port0 stalls mid-packet while port1 waits
    clear_logs();
    push_pkt(0, 4); drive();
    tick();
    push_pkt(1, 2); drive();
    tick();
    pause0 = 1'b1; drive();
    repeat (3) begin
      tick();
      #1;
      chk("bubble_p1_ready", 128'(in_tready[1]), 128'(0));
    end
    pause0 = 1'b0; drive();
    run_idle(1'b0);
    chk("bubble_len", 128'(olog.size()), 128'(6));
    if (olog.size() == 6) begin
      bad = 0;
      for (int i = 0; i < 6; i++) if (olog[i].src !== (i >= 4)) bad++;
      chk("bubble_order", 128'(bad), 128'(0));
    end
    chk("bubble_count", 128'(pkt_count), 128'(8'hDD));

    // fresh reset, then counter wrap and rr wrap with single-beat packets
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    clear_logs();
    for (int i = 0; i < 17; i++) push_pkt(0, 1);
    for (int i = 0; i < 3; i++) push_pkt(1, 1);
    drive();
    run_idle(1'b0);
    chk("wrap_len", 128'(olog.size()), 128'(20));
    if (olog.size() == 20) begin
      bad = 0;
      for (int i = 0; i < 20; i++) if (olog[i].src !== ((i < 6) ? 1'(i % 2) : 1'b0)) bad++;
      chk("wrap_rr_order", 128'(bad), 128'(0));
    end
    chk("wrap_count", 128'(pkt_count), 128'(8'h31));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
